// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and fixed AXI burst attributes for the
// icache/dcache memory arbiter.
//   rd_state_t - read burst FSM states
//   wr_state_t - write-back burst FSM states
//   BURST_*    - fixed len/size/burst encodings driven onto the bus
//   AXI_PROT   - fixed protection attribute
package mem_arb_pkg;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_ADDR = 2'd1,
    WR_DATA = 2'd2,
    WR_RESP = 2'd3
  } wr_state_t;

  localparam logic [7:0] BURST_LEN  = 8'd7;  // 8 beats per cache line
  localparam logic [2:0] BURST_SIZE = 3'd3;  // 8 bytes per beat
  localparam logic [1:0] BURST_WRAP = 2'd2;
  localparam logic [1:0] BURST_INCR = 2'd1;
  localparam logic [2:0] AXI_PROT   = 3'd6;

endpackage

// File: rtl/mem_axi_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   clk_i, rst_ni  - clock, async active-low reset
//   en_i           - grant enable; no grant is issued while low
//   req_i[1:0]     - request vector
//   upd_i          - load upd_idx_i into the last-grant register
//   upd_idx_i      - index of the requester that just finished
//   gnt_o[1:0]     - one-hot (or zero) grant
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       upd_idx_i,
  output logic [1:0] gnt_o
);

  logic last_q, last_d;

  // On a tie the requester that did not go last wins; last resets to 1
  // so requester 0 wins the first tie.
  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (req_i == 2'b11) gnt_o = last_q ? 2'b01 : 2'b10;
      else                gnt_o = req_i;
    end
  end

  always_comb begin
    last_d = last_q;
    if (upd_i) last_d = upd_idx_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_q <= 1'b1;
    else         last_q <= last_d;
  end

endmodule

// File: rtl/mem_axi_arbiter.sv
// mem_axi_arbiter: shares one AXI master between the icache (requester 0,
// read-only) and the dcache (requester 1, fills and write-backs). One burst
// is outstanding at a time; the read and write FSMs are never both busy.
//   clk, reset (async active-low)
//   s0_ar*/s0_r*         - icache fill request / beats
//   s1_ar*/s1_r*         - dcache fill request / beats
//   s1_aw*/s1_w*/s1_bvalid - dcache write-back address / beats / response pulse
//   m_axi_*              - core-side AXI master (fixed burst attributes)
//   err                  - sticky protocol/response error
//   dbg_rd_state_o / dbg_wr_state_o - FSM state visibility
// Handshakes: a transfer happens on any cycle where valid and ready are both
// high; valids are held until accepted and never depend on ready.
module mem_axi_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] s0_araddr,
  input  logic                  s0_arvalid,
  output logic                  s0_arready,
  output logic [DATA_WIDTH-1:0] s0_rdata,
  output logic                  s0_rlast,
  output logic                  s0_rvalid,
  input  logic                  s0_rready,
  input  logic [ADDR_WIDTH-1:0] s1_araddr,
  input  logic                  s1_arvalid,
  output logic                  s1_arready,
  output logic [DATA_WIDTH-1:0] s1_rdata,
  output logic                  s1_rlast,
  output logic                  s1_rvalid,
  input  logic                  s1_rready,
  input  logic [ADDR_WIDTH-1:0] s1_awaddr,
  input  logic                  s1_awvalid,
  output logic                  s1_awready,
  input  logic [DATA_WIDTH-1:0] s1_wdata,
  input  logic                  s1_wlast,
  input  logic                  s1_wvalid,
  output logic                  s1_wready,
  output logic                  s1_bvalid,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic                  err,
  output rd_state_t             dbg_rd_state_o,
  output wr_state_t             dbg_wr_state_o
);

  rd_state_t  rd_state_q, rd_state_d;
  wr_state_t  wr_state_q, wr_state_d;
  logic       owner_q, owner_d;
  logic [2:0] wcnt_q, wcnt_d;
  logic       err_q, err_d;
  logic [1:0] gnt;
  logic       rd_idle, wr_idle, ar_hs, r_hs, aw_hs, w_hs, r_done;
  logic       rd_err, w_err, b_err;

  assign rd_idle = (rd_state_q == RD_IDLE);
  assign wr_idle = (wr_state_q == WR_IDLE);

  // Write-back wins a same-cycle tie: no read grant while awvalid is up.
  rr_arb2 u_arb (
    .clk_i     (clk),
    .rst_ni    (reset),
    .en_i      (rd_idle && wr_idle && !s1_awvalid),
    .req_i     ({s1_arvalid, s0_arvalid}),
    .upd_i     (r_done),
    .upd_idx_i (owner_q),
    .gnt_o     (gnt)
  );

  // Read channel routing
  assign m_axi_arid    = {{(ID_WIDTH-1){1'b0}}, owner_q};
  assign m_axi_araddr  = owner_q ? s1_araddr : s0_araddr;
  assign m_axi_arlen   = BURST_LEN;
  assign m_axi_arsize  = BURST_SIZE;
  assign m_axi_arburst = BURST_WRAP;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'd0;
  assign m_axi_arprot  = AXI_PROT;
  assign m_axi_arvalid = (rd_state_q == RD_ADDR) && (owner_q ? s1_arvalid : s0_arvalid);
  assign s0_arready    = (rd_state_q == RD_ADDR) && !owner_q && m_axi_arready;
  assign s1_arready    = (rd_state_q == RD_ADDR) &&  owner_q && m_axi_arready;
  assign m_axi_rready  = (rd_state_q == RD_DATA) && (owner_q ? s1_rready : s0_rready);
  assign s0_rvalid     = (rd_state_q == RD_DATA) && !owner_q && m_axi_rvalid;
  assign s1_rvalid     = (rd_state_q == RD_DATA) &&  owner_q && m_axi_rvalid;
  assign s0_rdata      = m_axi_rdata;
  assign s1_rdata      = m_axi_rdata;
  assign s0_rlast      = m_axi_rlast;
  assign s1_rlast      = m_axi_rlast;

  // Write channel routing (dcache only)
  assign m_axi_awid    = {{(ID_WIDTH-1){1'b0}}, 1'b1};
  assign m_axi_awaddr  = s1_awaddr;
  assign m_axi_awlen   = BURST_LEN;
  assign m_axi_awsize  = BURST_SIZE;
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'd0;
  assign m_axi_awprot  = AXI_PROT;
  assign m_axi_awvalid = (wr_state_q == WR_ADDR) && s1_awvalid;
  assign s1_awready    = (wr_state_q == WR_ADDR) && m_axi_awready;
  assign m_axi_wdata   = s1_wdata;
  assign m_axi_wstrb   = {STRB_WIDTH{1'b1}};
  assign m_axi_wlast   = s1_wlast;
  assign m_axi_wvalid  = (wr_state_q == WR_DATA) && s1_wvalid;
  assign s1_wready     = (wr_state_q == WR_DATA) && m_axi_wready;
  assign m_axi_bready  = (wr_state_q == WR_RESP);
  assign s1_bvalid     = (wr_state_q == WR_RESP) && m_axi_bvalid;

  assign ar_hs  = m_axi_arvalid && m_axi_arready;
  assign r_hs   = m_axi_rvalid && m_axi_rready;
  assign aw_hs  = m_axi_awvalid && m_axi_awready;
  assign w_hs   = m_axi_wvalid && m_axi_wready;
  assign r_done = r_hs && m_axi_rlast;

  // Error sources: wrong id / non-OKAY response on reads and B, and a
  // burst whose wlast does not coincide with the 8th beat.
  assign rd_err = r_hs && ((m_axi_rid != m_axi_arid) || (m_axi_rresp != 2'd0));
  assign w_err  = w_hs && (s1_wlast != (wcnt_q == 3'd7));
  assign b_err  = s1_bvalid && ((m_axi_bresp != 2'd0) || (m_axi_bid != m_axi_awid));

  always_comb begin
    rd_state_d = rd_state_q;
    owner_d    = owner_q;
    case (rd_state_q)
      RD_IDLE: if (|gnt) begin
        rd_state_d = RD_ADDR;
        owner_d    = gnt[1];
      end
      RD_ADDR: if (ar_hs)  rd_state_d = RD_DATA;
      RD_DATA: if (r_done) rd_state_d = RD_IDLE;
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wcnt_d     = wcnt_q;
    case (wr_state_q)
      WR_IDLE: if (s1_awvalid && rd_idle) wr_state_d = WR_ADDR;
      WR_ADDR: if (aw_hs) begin
        wr_state_d = WR_DATA;
        wcnt_d     = 3'd0;
      end
      WR_DATA: if (w_hs) begin
        wcnt_d = wcnt_q + 3'd1;
        if (s1_wlast) wr_state_d = WR_RESP;
      end
      WR_RESP: if (m_axi_bvalid) wr_state_d = WR_IDLE;
      default: wr_state_d = WR_IDLE;
    endcase
  end

  assign err_d = err_q || rd_err || w_err || b_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_state_q <= RD_IDLE;
      wr_state_q <= WR_IDLE;
      owner_q    <= 1'b0;
      wcnt_q     <= 3'd0;
      err_q      <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      owner_q    <= owner_d;
      wcnt_q     <= wcnt_d;
      err_q      <= err_d;
    end
  end

  assign err            = err_q;
  assign dbg_rd_state_o = rd_state_q;
  assign dbg_wr_state_o = wr_state_q;

endmodule
